ifu_npc_seq: RTL and testbench

- Instruction fetch and next-PC unit for the single-cycle MIPS core; sits between instruction memory and the control decoder.
- Consumes the decoder's 3-bit nPCOp, the ALU zero flag and the rs register value, and holds the program counter.
- Fetches each instruction over a req/ack handshake, presents it to the core, then commits the next PC when the core signals completion.

---
 rtl/ifu_npc_seq.sv | 128 ++++++++++++
 tb/tb_ifu_npc_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_npc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifu_npc_seq: instruction fetch (req/ack) and next-PC sequencer for the    |
// | single-cycle MIPS core. Optional macro IFU_MISALIGN_TRAP_EN adds HALT.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ifu_npc_seq #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       npc_op,
  input  logic             zero,
  input  logic [31:0]      rs_data,
  input  logic             exec_done,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic [CNT_W-1:0] retired,
  output logic             trap
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      pc4_w;
  logic [31:0]      br_tgt_w;
  logic [31:0]      npc_w;

  assign pc4_w    = pc_q + 32'd4;
  assign br_tgt_w = pc4_w + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    npc_w = pc4_w;
    case (npc_op)
      3'b001:  npc_w = zero ? br_tgt_w : pc4_w;
      3'b010:  npc_w = {pc4_w[31:28], instr_q[25:0], 2'b00};
      3'b011:  npc_w = rs_data;
      default: npc_w = pc4_w;
    endcase
  end

`ifdef IFU_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
`ifdef IFU_MISALIGN_TRAP_EN
    trap_d    = trap_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
`ifdef IFU_MISALIGN_TRAP_EN
          // Keep the faulting target unmasked so it is visible for debug.
          pc_d = npc_w;
          if (npc_w[1:0] != 2'b00) begin
            trap_d  = 1'b1;
            state_d = S_HALT;
          end
`else
          pc_d = {npc_w[31:2], 2'b00};
`endif
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_RESET;
      instr_q   <= 32'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trap_q <= 1'b0;
    else          trap_q <= trap_d;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc4         = pc4_w;
  assign instr       = instr_q;
  assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_npc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ifu_npc_seq: scoreboard bench for ifu_npc_seq with a behavioural model |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ifu_npc_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  npc_op;
  logic        zero;
  logic [31:0] rs_data;
  logic        exec_done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] retired;
  logic        trap;

  ifu_npc_seq dut (
    .clk(clk), .reset_n(reset_n), .npc_op(npc_op), .zero(zero), .rs_data(rs_data),
    .exec_done(exec_done), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc4(pc4), .retired(retired), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ret;
  } exec_t;

  logic [31:0] q_fetch[$];
  exec_t       q_exec[$];

  int checks = 0;
  int errors = 0;
  bit run = 0;
  int exp_phase = 0;  // 0 fetch, 1 exec, 2 halted

  logic [31:0] m_pc;
  logic [31:0] m_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [31:0] w,
                                            input logic [2:0] op, input bit z,
                                            input logic [31:0] rs);
    logic [31:0] nxt;
    logic [15:0] imm;
    int off;
    imm = w[15:0];
    off = int'($signed(imm));
    case (op)
      3'd1:    nxt = z ? cur + 32'd4 + 32'(off * 4) : cur + 32'd4;
      3'd2:    nxt = ((cur + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      3'd3:    nxt = rs;
      default: nxt = cur + 32'd4;
    endcase
    return nxt;
  endfunction

  // Monitor: protocol phase every cycle, scoreboard pops on fetch/commit.
  always @(negedge clk) begin
    if (run && reset_n) begin
      case (exp_phase)
        0: begin chk("phase_fetch_req", 32'(imem_req), 1); chk("phase_fetch_valid", 32'(instr_valid), 0); end
        1: begin chk("phase_exec_req", 32'(imem_req), 0); chk("phase_exec_valid", 32'(instr_valid), 1); end
        default: begin chk("halt_req", 32'(imem_req), 0); chk("halt_valid", 32'(instr_valid), 0); end
      endcase
      if (imem_req && imem_ack) begin
        if (q_fetch.size() == 0) chk("fetch_unexpected", imem_addr, 32'hFFFF_FFFF);
        else chk("fetch_addr", imem_addr, q_fetch.pop_front());
      end
      if (instr_valid && exec_done) begin
        if (q_exec.size() == 0) chk("commit_unexpected", pc, 32'hFFFF_FFFF);
        else begin
          exec_t e;
          e = q_exec.pop_front();
          chk("exec_instr", instr, e.word);
          chk("exec_pc", pc, e.pc);
          chk("exec_pc4", pc4, e.pc4);
          chk("exec_retired", retired, e.ret);
          chk("exec_trap", 32'(trap), 0);
        end
      end
    end
  end

  task automatic do_instr(input int ad, input int ed, input logic [2:0] op, input bit z,
                          input logic [31:0] rs, input logic [31:0] word, input bit stray);
    logic [31:0] nxt;
    exec_t e;
    q_fetch.push_back(m_pc);
    exp_phase = 0;
    imem_ack = 1'b0;
    repeat (ad) begin @(posedge clk); #1; end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    exp_phase = 1;
    imem_ack = stray;
    imem_rdata = ~word;
    npc_op = op; zero = z; rs_data = rs;
    exec_done = 1'b0;
    repeat (ed) begin @(posedge clk); #1; end
    e.word = word; e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.ret = m_ret;
    q_exec.push_back(e);
    exec_done = 1'b1;
    nxt = model_npc(m_pc, word, op, z, rs);
    @(posedge clk); #1;
    exec_done = 1'b0;
    imem_ack = 1'b0;
    m_ret = m_ret + 32'd1;
`ifdef IFU_MISALIGN_TRAP_EN
    m_pc = nxt;
    exp_phase = (nxt[1:0] != 2'b00) ? 2 : 0;
`else
    m_pc = nxt & ~32'h3;
    exp_phase = 0;
`endif
  endtask

  initial begin
    reset_n = 1'b0; npc_op = 3'd0; zero = 1'b0; rs_data = 32'd0;
    exec_done = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_trap", 32'(trap), 0);
    reset_n = 1'b1;
    m_pc = 32'h0000_3000; m_ret = 32'd0;
    exp_phase = 0;
    run = 1;

    // Sequential fetches with ack held, then branch, jump and register jump.
    do_instr(0, 0, 3'd0, 0, 32'd0, 32'h2402_0001, 0);
    do_instr(0, 0, 3'd0, 0, 32'd0, 32'h2402_0002, 0);
    do_instr(0, 0, 3'd0, 0, 32'd0, 32'h2402_0003, 0);
    chk("retired_after3", retired, 32'd3);
    do_instr(0, 0, 3'd0, 0, 32'd0, 32'h0, 0);
    do_instr(0, 0, 3'd1, 1, 32'd0, 32'h1000_FFFE, 0);
    do_instr(0, 0, 3'd0, 0, 32'd0, 32'h0, 0);
    do_instr(0, 0, 3'd1, 0, 32'd0, 32'h1000_FFFE, 0);
    do_instr(0, 0, 3'd3, 0, 32'h0000_3000, 32'h0, 0);
    do_instr(0, 0, 3'd2, 0, 32'd0, 32'h0C00_0C40, 0);
    do_instr(0, 0, 3'd3, 0, 32'h0000_3020, 32'h0, 0);
    chk("after_jr_pc", pc, 32'h0000_3020);
    do_instr(3, 4, 3'd0, 0, 32'd0, 32'hDEAD_BEEF, 1);

    for (int i = 0; i < 150; i++) begin
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
               1'($urandom_range(0, 1)));
    end

    // Abandon an instruction in EXEC with an asynchronous reset.
    do_instr(0, 0, 3'd3, 0, 32'h0000_3040, 32'h0, 0);
    q_fetch.push_back(m_pc);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    exp_phase = 1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_pc", pc, 32'h0000_3040);
    reset_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0000_3000);
    chk("async_rst_valid", 32'(instr_valid), 0);
    chk("async_rst_retired", retired, 32'd0);
    q_exec.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_pc = 32'h0000_3000; m_ret = 32'd0; exp_phase = 0;
    #1;
    chk("post_rst_req", 32'(imem_req), 1);
    do_instr(1, 0, 3'd0, 0, 32'd0, 32'h0, 0);

    // Misaligned register jump target.
    do_instr(0, 0, 3'd3, 0, 32'h0000_3040, 32'h0, 0);
    do_instr(0, 0, 3'd3, 0, 32'h0000_3022, 32'h0, 0);
`ifdef IFU_MISALIGN_TRAP_EN
    imem_ack = 1'b1;
    repeat (10) begin
      exec_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; exec_done = 1'b0;
    chk("trap_set", 32'(trap), 1);
    chk("trap_pc", pc, 32'h0000_3022);
`else
    chk("no_trap", 32'(trap), 0);
    do_instr(0, 0, 3'd0, 0, 32'd0, 32'h0, 0);
    chk("masked_pc", pc, 32'h0000_3024);
`endif
    @(negedge clk);
    run = 0;
    chk("fetch_q_empty", 32'(q_fetch.size()), 0);
    chk("exec_q_empty", 32'(q_exec.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
